// File: rtl/axi_rd_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_pkg
// Shared definitions for the two-port AXI read-command arbiter: arbiter FSM
// state encoding, port index constants and the width of the port-0 streak
// counter.
// -----------------------------------------------------------------------------
package axi_rd_pkg;

    // Arbiter FSM: idle / command presented to master / master transferring.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_XFER  = 2'd2
    } state_e;

    // Port indices as seen on the owner output.
    localparam logic PORT_HDMI = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    // Consecutive port-0 grants while port 1 waits; saturates at all-ones.
    localparam int                 STREAK_W   = 4;
    localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

endpackage

// File: rtl/arb_pick2.sv
// -----------------------------------------------------------------------------
// arb_pick2
// Combinational winner select between two requesters.
//
// Parameters:
//   PRIORITY_MODE  1 = port 0 priority with streak limit, 0 = round-robin
//   MAX_STREAK     port-0 grants allowed in a row while port 1 is pending
// Ports:
//   kick0_i, kick1_i  requests from port 0 / port 1
//   last_i            port that won the previous grant
//   streak_i          consecutive port-0 grants made while port 1 was pending
//   winner_o          index of the winning port (only meaningful if a kick is high)
// -----------------------------------------------------------------------------
module arb_pick2
    import axi_rd_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = 1,
    parameter int unsigned MAX_STREAK    = 4
) (
    input  logic                kick0_i,
    input  logic                kick1_i,
    input  logic                last_i,
    input  logic [STREAK_W-1:0] streak_i,
    output logic                winner_o
);

    always_comb begin
        winner_o = PORT_HDMI;
        if (kick0_i && kick1_i) begin
            if (PRIORITY_MODE != 0) begin
                // Port 0 keeps winning until it has starved port 1 for
                // MAX_STREAK grants in a row.
                winner_o = (streak_i == STREAK_W'(MAX_STREAK)) ? PORT_AUX : PORT_HDMI;
            end else begin
                winner_o = ~last_i;
            end
        end else if (kick1_i) begin
            winner_o = PORT_AUX;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter
// Shares one AXI read master (kick/busy/addr/num) between the HDMI scan-out
// reader (port 0) and a secondary DMA reader (port 1). One command is granted
// at a time; the master's busy is reflected only to the owning port and the
// owner output steers returned read data.
//
// Parameters:
//   PRIORITY_MODE  1 = port 0 priority with streak limit, 0 = round-robin
//   MAX_STREAK     1..15, port-0 grants in a row while port 1 waits
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   kick0/1, read_addr0/1, read_num0/1  requester commands
//   busy0/1                          per-requester view of m_busy
//   m_kick, m_read_addr, m_read_num  command to the master
//   m_busy                           master busy
//   owner, owner_valid               granted port and its validity
// -----------------------------------------------------------------------------
module axi_read_arbiter
    import axi_rd_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = 1,
    parameter int unsigned MAX_STREAK    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kick0,
    input  logic        kick1,
    input  logic [31:0] read_addr0,
    input  logic [31:0] read_addr1,
    input  logic [31:0] read_num0,
    input  logic [31:0] read_num1,
    output logic        busy0,
    output logic        busy1,
    output logic        m_kick,
    input  logic        m_busy,
    output logic [31:0] m_read_addr,
    output logic [31:0] m_read_num,
    output logic        owner,
    output logic        owner_valid
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         num_q, num_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                last_q, last_d;
    logic                winner;

    arb_pick2 #(
        .PRIORITY_MODE (PRIORITY_MODE),
        .MAX_STREAK    (MAX_STREAK)
    ) u_pick (
        .kick0_i  (kick0),
        .kick1_i  (kick1),
        .last_i   (last_q),
        .streak_i (streak_q),
        .winner_o (winner)
    );

    // NOTE: every signal gets its hold value before the case statement so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        num_d    = num_q;
        streak_d = streak_q;
        last_d   = last_q;
        unique case (state_q)
            S_IDLE: begin
                // A busy master in idle is still draining a previous burst.
                if ((kick0 || kick1) && !m_busy) begin
                    state_d = S_ISSUE;
                    owner_d = winner;
                    last_d  = winner;
                    addr_d  = (winner == PORT_AUX) ? read_addr1 : read_addr0;
                    num_d   = (winner == PORT_AUX) ? read_num1  : read_num0;
                    if (winner == PORT_HDMI && kick1) begin
                        streak_d = (streak_q == STREAK_SAT) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end
            end
            S_ISSUE: if (m_busy)  state_d = S_XFER;
            S_XFER:  if (!m_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering. The command registers
    // are reset too, since m_read_addr/m_read_num are visible outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= PORT_HDMI;
            addr_q   <= '0;
            num_q    <= '0;
            streak_q <= '0;
            last_q   <= PORT_AUX;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            num_q    <= num_d;
            streak_q <= streak_d;
            last_q   <= last_d;
        end
    end

    assign m_kick      = (state_q == S_ISSUE);
    assign owner_valid = (state_q != S_IDLE);
    assign owner       = owner_q;
    assign m_read_addr = addr_q;
    assign m_read_num  = num_q;

    // Only the owner sees the master busy, so a waiting requester keeps its
    // kick asserted.
    assign busy0 = owner_valid && (owner_q == PORT_HDMI) && m_busy;
    assign busy1 = owner_valid && (owner_q == PORT_AUX)  && m_busy;

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares one AXI read master (kick/busy/addr/num command interface) between two read requesters: port 0 is the HDMI scan-out address generator, port 1 is a secondary reader such as a stream or capture DMA. The block accepts kicks on both ports, grants one at a time, forwards the latched command to the master, and reflects the master's busy back to the owner only. Starvation of port 1 is bounded. An `owner` output lets the read-data demux route returned words.

## Interface
- `PRIORITY_MODE`, default 1: 1 = port 0 strict priority with streak limit; 0 = round-robin.
- `MAX_STREAK`, default 4: maximum consecutive port-0 grants while port 1 is pending (mode 1 only); range 1..15.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `kick0`, `kick1` in 1 each: requester command request; held until that port's busy is seen high.
- `read_addr0`, `read_addr1` in 32 each: byte address, valid while the matching kick is high.
- `read_num0`, `read_num1` in 32 each: word count, valid while the matching kick is high.
- `busy0`, `busy1` out 1 each: per-requester busy view.
- `m_kick` out 1: command to the master.
- `m_busy` in 1: master busy.
- `m_read_addr` out 32: latched address of the granted command.
- `m_read_num` out 32: latched word count of the granted command.
- `owner` out 1: index of the granted port.
- `owner_valid` out 1: high while a granted command is in ISSUE or XFER.

## Operation
- States:
  - S_IDLE: no owner.
  - S_ISSUE: `m_kick`=1, waiting for `m_busy`=1.
  - S_XFER: waiting for `m_busy`=0.
- S_IDLE → S_ISSUE when (`kick0`|`kick1`) and `m_busy`=0. On that edge, latch `owner`, `m_read_addr` and `m_read_num` from the winner.
- If `m_busy`=1 in S_IDLE (master still draining), stay in S_IDLE.
- S_ISSUE → S_XFER when `m_busy`=1.
- S_XFER → S_IDLE when `m_busy`=0.
- Busy view: `busy[i]` = `m_busy` when `owner_valid`=1 and `owner`=i, else 0.
  - A non-owner that is kicking therefore keeps waiting with its kick high.
  - The owner sees the acceptance edge exactly when the master does.
- Arbitration is evaluated only in S_IDLE.
  - Single requester: it wins.
  - Both requesting, mode 0: the port that did not win last grant wins. `last` resets to 1, so port 0 wins first.
  - Both requesting, mode 1: port 0 wins unless `streak` = `MAX_STREAK`, in which case port 1 wins.
- `streak` (4-bit) updates on each grant:
  - Port 0 granted while `kick1`=1: `streak`+1, saturating.
  - Port 0 granted while `kick1`=0: `streak` cleared.
  - Port 1 granted: `streak` cleared.
- Kicks from the owner during S_XFER are ignored; it is re-arbitrated from S_IDLE.
- A kick dropped before grant is simply not served; no state is retained.
- Latched addr/num remain stable from S_ISSUE through S_XFER regardless of requester inputs.

## Timing
- Reset values:
  - state S_IDLE; `m_kick`, `owner`, `owner_valid`, `busy0`, `busy1` = 0.
  - `m_read_addr`, `m_read_num` = 0; `streak` = 0; `last` = 1.
- Kick first high in S_IDLE at cycle n with `m_busy`=0 → `m_kick`=1 and `owner_valid`=1 at n+1.
- `m_kick` drops the cycle after `m_busy` is sampled high.
- `busy[i]` is combinational from `m_busy` (zero added latency).
- Back-to-back grants: `m_busy` falls at cycle k → S_IDLE at k+1 → next `m_kick` at k+2. Minimum one idle cycle between commands.
- `m_kick` and `owner_valid` are registered (decoded from state flops). `busy0`/`busy1` are combinational.
- Reset mid-operation: all outputs return to reset values on the next edge; the in-flight master transaction is abandoned. The master and requesters share `rst`.

## Structure
- Shared package `axi_rd_pkg`: state encoding (S_IDLE/S_ISSUE/S_XFER), port index constants (PORT_HDMI=0, PORT_AUX=1), streak width.
- Optional sub-module `arb_pick2`: combinational winner select from (`kick0`, `kick1`, `last`, `streak`, mode). Everything else lives in the top module.

## Test plan
- Port 0 alone, addr 0x0, num 256; master raises busy 3 cycles after `m_kick` and holds it 20 cycles → `m_read_addr`=0x0, `busy0` mirrors `m_busy`, `busy1`=0 throughout, `owner`=0.
- Both kick in the same cycle, mode 1 → port 0 served first; port 1 `m_kick` appears exactly 2 cycles after `m_busy` falls; `busy1` stays 0 until its own acceptance.
- Mode 1, `MAX_STREAK`=4, both kicking continuously → grant sequence 0,0,0,0,1,0,0,0,0,1.
- Mode 0, both kicking continuously → grants alternate 0,1,0,1 starting with 0.
- `m_busy` high at kick time (master draining) → no `m_kick` until `m_busy`=0, then `m_kick` the next cycle.
- `rst` asserted while in S_XFER → next cycle `m_kick`=0, `owner_valid`=0, `busy0`=`busy1`=0, `streak`=0.
